// File: rtl/register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_file_mp : multi-read-port register file with byte-lane partial   |
// | writes, write-to-read forwarding and a sequenced soft clear.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module register_file_mp #(
  parameter int DEPTH     = 32,
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 5,
  parameter int NUM_RD    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write_enb,
  input  logic [2:0]                  pppsel,
  input  logic [ADDRWIDTH-1:0]        addr_wr,
  input  logic [DATAWIDTH-1:0]        data_in,
  input  logic [NUM_RD*ADDRWIDTH-1:0] addr_rd,
  output logic [NUM_RD*DATAWIDTH-1:0] data_out,
  input  logic                        clr_req,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic                        wr_dropped
);

  localparam int                   c_NLANES = DATAWIDTH / 8;
  localparam int                   c_IW     = $clog2(DEPTH);
  localparam logic [ADDRWIDTH:0]   c_DEPTH  = (ADDRWIDTH + 1)'(DEPTH);
  localparam logic [c_IW-1:0]      c_LAST   = c_IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_IW-1:0]     r_clr_ptr;
  logic                r_clr_busy;
  logic                r_clr_done;
  logic                r_wr_dropped;

  logic [DATAWIDTH-1:0] w_mem [1:DEPTH-1];
  logic [c_NLANES-1:0]  w_lane_mask;
  logic [DATAWIDTH-1:0] w_bit_mask;
  logic [c_IW-1:0]      w_wr_idx;
  logic                 w_wr_ok;
  logic [DATAWIDTH-1:0] w_wr_merged;

  always_comb begin
    w_lane_mask = '0;
    for (int k = 0; k < c_NLANES; k++) begin
      case (pppsel)
        3'b000:  w_lane_mask[k] = 1'b1;
        3'b001:  w_lane_mask[k] = (k < c_NLANES / 2);
        3'b010:  w_lane_mask[k] = (k >= c_NLANES / 2);
        3'b011:  w_lane_mask[k] = (k % 2 == 0);
        3'b100:  w_lane_mask[k] = (k % 2 == 1);
        default: w_lane_mask[k] = 1'b0;
      endcase
    end
  end

  // Lane 0 is the most significant byte: MSB-first numbering on a [W-1:0] vector.
  for (genvar k = 0; k < c_NLANES; k++) begin : g_lane
    assign w_bit_mask[DATAWIDTH-1-8*k -: 8] = {8{w_lane_mask[k]}};
  end

  assign w_wr_idx    = addr_wr[c_IW-1:0];
  assign w_wr_ok     = write_enb && !r_clr_busy && (addr_wr != '0) && ({1'b0, addr_wr} < c_DEPTH);
  assign w_wr_merged = (w_mem[w_wr_idx] & ~w_bit_mask) | (data_in & w_bit_mask);

  for (genvar e = 1; e < DEPTH; e++) begin : g_entry
    logic [DATAWIDTH-1:0] r_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_q <= '0;
      end else if (r_clr_busy && (r_clr_ptr == c_IW'(e))) begin
        r_q <= '0;
      end else if (w_wr_ok && (w_wr_idx == c_IW'(e))) begin
        r_q <= w_wr_merged;
      end
    end
    assign w_mem[e] = r_q;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDRWIDTH-1:0] w_addr;
    logic                 w_valid;
    logic                 w_fwd;
    logic [DATAWIDTH-1:0] w_stored;
    assign w_addr   = addr_rd[p*ADDRWIDTH +: ADDRWIDTH];
    assign w_valid  = (w_addr != '0) && ({1'b0, w_addr} < c_DEPTH);
    assign w_stored = w_valid ? w_mem[w_addr[c_IW-1:0]] : '0;
    // w_wr_ok already excludes clear-in-progress and out-of-range targets.
    assign w_fwd    = w_wr_ok && (addr_wr == w_addr);
    assign data_out[p*DATAWIDTH +: DATAWIDTH] = w_fwd ? w_wr_merged : w_stored;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_clr_ptr    <= c_IW'(1);
      r_clr_busy   <= 1'b0;
      r_clr_done   <= 1'b0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_clr_done   <= 1'b0;
      r_wr_dropped <= write_enb && r_clr_busy;
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state    <= S_CLEAR;
            r_clr_busy <= 1'b1;
            r_clr_ptr  <= c_IW'(1);
          end
        end
        S_CLEAR: begin
          if (r_clr_ptr == c_LAST) begin
            r_state    <= S_IDLE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
            r_clr_ptr  <= c_IW'(1);
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clr_busy   = r_clr_busy;
  assign clr_done   = r_clr_done;
  assign wr_dropped = r_wr_dropped;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_file_mp : randomized bench for register_file_mp against a     |
// | behavioural byte-lane model.  Rev 1.0                                     |
// +--------------------------------------------------------------------------+
module tb_register_file_mp;

  localparam int DEPTH  = 32;
  localparam int DW     = 64;
  localparam int AW     = 5;
  localparam int NRD    = 3;
  localparam int DEPTH8 = 8;
  localparam int DW8    = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            write_enb;
  logic [2:0]      pppsel;
  logic [AW-1:0]   addr_wr;
  logic [DW-1:0]   data_in;
  logic [NRD*AW-1:0] addr_rd;
  logic [NRD*DW-1:0] data_out;
  logic            clr_req, clr_busy, clr_done, wr_dropped;

  logic            we8;
  logic [2:0]      sel8;
  logic [AW-1:0]   aw8;
  logic [DW8-1:0]  din8;
  logic [AW-1:0]   ar8;
  logic [DW8-1:0]  dout8;
  logic            clr_req8, busy8, done8, drop8;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_mem  [DEPTH];
  logic [63:0] m_mem8 [DEPTH8];
  bit          m_busy;

  register_file_mp #(.DEPTH(DEPTH), .DATAWIDTH(DW), .ADDRWIDTH(AW), .NUM_RD(NRD)) u_dut (
    .clk(clk), .reset(reset), .write_enb(write_enb), .pppsel(pppsel), .addr_wr(addr_wr),
    .data_in(data_in), .addr_rd(addr_rd), .data_out(data_out), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_dropped(wr_dropped)
  );

  register_file_mp #(.DEPTH(DEPTH8), .DATAWIDTH(DW8), .ADDRWIDTH(AW), .NUM_RD(1)) u_dut8 (
    .clk(clk), .reset(reset), .write_enb(we8), .pppsel(sel8), .addr_wr(aw8),
    .data_in(din8), .addr_rd(ar8), .data_out(dout8), .clr_req(clr_req8),
    .clr_busy(busy8), .clr_done(done8), .wr_dropped(drop8)
  );

  always #5 clk = ~clk;

  // Byte k counts from the most significant byte of a word of nl bytes.
  function automatic bit lane_on(input logic [2:0] mode, input int k, input int nl);
    case (mode)
      3'd0:    return 1'b1;
      3'd1:    return k < nl / 2;
      3'd2:    return k >= nl / 2;
      3'd3:    return (k % 2) == 0;
      3'd4:    return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [2:0] mode, input int dw);
    logic [63:0] r;
    logic [63:0] bm;
    int nl;
    r  = old_v;
    nl = dw / 8;
    for (int k = 0; k < nl; k++) begin
      if (lane_on(mode, k, nl)) begin
        bm = 64'hFF << (8 * (nl - 1 - k));
        r  = (r & ~bm) | (new_v & bm);
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_read(input int a);
    if (a == 0 || a >= DEPTH) return 64'h0;
    if (write_enb && !m_busy && int'(addr_wr) == a) return merge(m_mem[a], data_in, pppsel, DW);
    return m_mem[a];
  endfunction

  function automatic logic [31:0] exp_read8(input int a);
    logic [63:0] v;
    if (a == 0 || a >= DEPTH8) return 32'h0;
    v = m_mem8[a];
    if (we8 && int'(aw8) == a) v = merge(m_mem8[a], {32'h0, din8}, sel8, DW8);
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset && write_enb && !m_busy && addr_wr != '0)
      m_mem[addr_wr] = merge(m_mem[addr_wr], data_in, pppsel, DW);
    if (reset && we8 && int'(aw8) != 0 && int'(aw8) < DEPTH8)
      m_mem8[aw8[2:0]] = merge(m_mem8[aw8[2:0]], {32'h0, din8}, sel8, DW8);
    #1;
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'h0;
    for (int i = 0; i < DEPTH8; i++) m_mem8[i] = 64'h0;
    m_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; write_enb = 1'b0; pppsel = 3'd0; addr_wr = '0; data_in = '0; addr_rd = '0;
    clr_req = 1'b0; we8 = 1'b0; sel8 = 3'd0; aw8 = '0; din8 = '0; ar8 = '0; clr_req8 = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", clr_done); end
    checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", wr_dropped); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b exp 0", busy8); end
    for (int i = 0; i < 4; i++) begin
      addr_rd = 15'($urandom);
      ar8 = 5'($urandom);
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (data_out[p*DW +: DW] !== 64'h0) begin
          errors++; $display("FAIL reset_read port %0d got %h exp 0", p, data_out[p*DW +: DW]);
        end
      end
      checks++; if (dout8 !== 32'h0) begin errors++; $display("FAIL reset_read8 got %h exp 0", dout8); end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", clr_busy); end
  endtask

  task automatic test_basic();
    write_enb = 1'b1; addr_wr = 5'd5; pppsel = 3'd0; data_in = 64'h0123_4567_89AB_CDEF;
    step();
    write_enb = 1'b0;
    addr_rd = {5'd5, 5'd5, 5'd5};
    #1;
    for (int p = 0; p < NRD; p++) begin
      checks++;
      if (data_out[p*DW +: DW] !== 64'h0123_4567_89AB_CDEF) begin
        errors++; $display("FAIL basic_r5 port %0d got %h exp 0123456789abcdef", p, data_out[p*DW +: DW]);
      end
    end
    addr_rd = {5'd0, 5'd5, 5'd0};
    #1;
    checks++; if (data_out[0 +: DW] !== 64'h0) begin errors++; $display("FAIL basic_r0 port 0 got %h exp 0", data_out[0 +: DW]); end
    checks++; if (data_out[2*DW +: DW] !== 64'h0) begin errors++; $display("FAIL basic_r0 port 2 got %h exp 0", data_out[2*DW +: DW]); end
  endtask

  task automatic test_partial();
    for (int m = 1; m <= 4; m++) begin
      write_enb = 1'b1; addr_wr = 5'd7; pppsel = 3'd0; data_in = '1;
      step();
      pppsel = 3'(m); data_in = '0;
      step();
      write_enb = 1'b0;
      addr_rd = {5'd7, 5'd7, 5'd7};
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (data_out[p*DW +: DW] !== m_mem[7]) begin
          errors++; $display("FAIL partial mode %0d port %0d got %h exp %h", m, p, data_out[p*DW +: DW], m_mem[7]);
        end
      end
    end
  endtask

  task automatic test_forward();
    logic [63:0] e;
    write_enb = 1'b1; addr_wr = 5'd9; pppsel = 3'd0; data_in = {8{8'hAA}};
    step();
    pppsel = 3'd3; data_in = {8{8'h55}}; addr_rd = {5'd4, 5'd9, 5'd9};
    #1;
    checks++; if (data_out[0 +: DW] !== 64'h55AA_55AA_55AA_55AA) begin errors++; $display("FAIL fwd_even got %h exp 55aa55aa55aa55aa", data_out[0 +: DW]); end
    e = exp_read(4);
    checks++; if (data_out[2*DW +: DW] !== e) begin errors++; $display("FAIL fwd_other got %h exp %h", data_out[2*DW +: DW], e); end
    step();
    write_enb = 1'b0;
    #1;
    checks++; if (data_out[DW +: DW] !== 64'h55AA_55AA_55AA_55AA) begin errors++; $display("FAIL fwd_stored got %h exp 55aa55aa55aa55aa", data_out[DW +: DW]); end
    write_enb = 1'b1; pppsel = 3'd5; data_in = '1;
    #1;
    checks++; if (data_out[0 +: DW] !== 64'h55AA_55AA_55AA_55AA) begin errors++; $display("FAIL fwd_mode5 got %h exp 55aa55aa55aa55aa", data_out[0 +: DW]); end
    step();
    write_enb = 1'b0;
    #1;
    checks++; if (data_out[0 +: DW] !== 64'h55AA_55AA_55AA_55AA) begin errors++; $display("FAIL mode5_store got %h exp 55aa55aa55aa55aa", data_out[0 +: DW]); end
  endtask

  task automatic test_random();
    logic [63:0] e;
    for (int i = 0; i < 150; i++) begin
      write_enb = 1'($urandom_range(0, 1));
      addr_wr   = 5'($urandom);
      pppsel    = 3'($urandom_range(0, 7));
      data_in   = {$urandom, $urandom};
      addr_rd   = 15'($urandom);
      if ($urandom_range(0, 1) == 1) addr_rd[0 +: AW] = addr_wr;
      #1;
      for (int p = 0; p < NRD; p++) begin
        e = exp_read(int'(addr_rd[p*AW +: AW]));
        checks++;
        if (data_out[p*DW +: DW] !== e) begin
          errors++; $display("FAIL random i %0d port %0d addr %0d got %h exp %h", i, p, addr_rd[p*AW +: AW], data_out[p*DW +: DW], e);
        end
      end
      checks++; if (wr_dropped !== 1'b0) begin errors++; $display("FAIL random_drop i %0d got %b exp 0", i, wr_dropped); end
      step();
    end
    write_enb = 1'b0;
  endtask

  task automatic fill_all();
    for (int a = 1; a < DEPTH; a++) begin
      write_enb = 1'b1; addr_wr = 5'(a); pppsel = 3'd0; data_in = {$urandom, $urandom} | 64'h1;
      step();
    end
    write_enb = 1'b0;
  endtask

  task automatic test_clear();
    logic [63:0] e;
    int busy_cnt, done_cnt;
    fill_all();
    busy_cnt = 0; done_cnt = 0;
    clr_req = 1'b1; write_enb = 1'b1; addr_wr = 5'd31; pppsel = 3'd0; data_in = 64'hFEED_0000_0000_BEEF;
    step();
    m_busy = 1'b1;
    clr_req = 1'b0; write_enb = 1'b0;
    for (int t = 1; t <= 34; t++) begin
      addr_rd = {5'($urandom), 5'(t - 1), 5'(t)};
      if (t == 3) begin
        write_enb = 1'b1; addr_wr = 5'd1; pppsel = 3'd0; data_in = 64'hDEAD_BEEF_CAFE_F00D;
        addr_rd[2*AW +: AW] = 5'd1;
      end
      #1;
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      checks++; if (clr_busy !== (t <= 31)) begin errors++; $display("FAIL clr_busy t %0d got %b exp %b", t, clr_busy, (t <= 31)); end
      checks++; if (clr_done !== (t == 32)) begin errors++; $display("FAIL clr_done t %0d got %b exp %b", t, clr_done, (t == 32)); end
      checks++; if (wr_dropped !== (t == 4)) begin errors++; $display("FAIL wr_dropped t %0d got %b exp %b", t, wr_dropped, (t == 4)); end
      for (int p = 0; p < NRD; p++) begin
        e = exp_read(int'(addr_rd[p*AW +: AW]));
        checks++;
        if (data_out[p*DW +: DW] !== e) begin
          errors++; $display("FAIL clr_read t %0d port %0d got %h exp %h", t, p, data_out[p*DW +: DW], e);
        end
      end
      step();
      write_enb = 1'b0;
      if (t <= 31) m_mem[t] = 64'h0;
      if (t == 31) m_busy = 1'b0;
    end
    checks++; if (busy_cnt != 31) begin errors++; $display("FAIL clr_busy_len got %0d exp 31", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_cnt got %0d exp 1", done_cnt); end
    for (int a = 0; a < DEPTH; a += NRD) begin
      addr_rd = {5'((a + 2) % DEPTH), 5'((a + 1) % DEPTH), 5'(a)};
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (data_out[p*DW +: DW] !== 64'h0) begin
          errors++; $display("FAIL clr_sweep addr %0d got %h exp 0", addr_rd[p*AW +: AW], data_out[p*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_clear_retrigger();
    clr_req = 1'b1;
    step();
    for (int t = 1; t <= 66; t++) begin
      if (t == 33) clr_req = 1'b0;
      #1;
      checks++;
      if (clr_busy !== !(t == 32 || t >= 64)) begin
        errors++; $display("FAIL retrig_busy t %0d got %b exp %b", t, clr_busy, !(t == 32 || t >= 64));
      end
      checks++;
      if (clr_done !== (t == 32 || t == 64)) begin
        errors++; $display("FAIL retrig_done t %0d got %b exp %b", t, clr_done, (t == 32 || t == 64));
      end
      step();
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt;
    fill_all();
    clr_req = 1'b1;
    step();
    m_busy = 1'b1;
    clr_req = 1'b0;
    for (int t = 1; t < 10; t++) begin
      step();
      m_mem[t] = 64'h0;
    end
    reset = 1'b0;
    model_zero();
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", clr_done); end
    for (int a = 0; a < DEPTH; a += NRD) begin
      addr_rd = {5'((a + 2) % DEPTH), 5'((a + 1) % DEPTH), 5'(a)};
      #1;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (data_out[p*DW +: DW] !== 64'h0) begin
          errors++; $display("FAIL midrst_read addr %0d got %h exp 0", addr_rd[p*AW +: AW], data_out[p*DW +: DW]);
        end
      end
    end
    step();
    reset = 1'b1;
    done_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_after got %0d active cycles exp 0", done_cnt); end
    write_enb = 1'b1; addr_wr = 5'd31; pppsel = 3'd0; data_in = 64'h1357_9BDF_2468_ACE0;
    step();
    write_enb = 1'b0; addr_rd = {5'd0, 5'd0, 5'd31};
    #1;
    checks++; if (data_out[0 +: DW] !== 64'h1357_9BDF_2468_ACE0) begin errors++; $display("FAIL midrst_r31 got %h exp 13579bdf2468ace0", data_out[0 +: DW]); end
  endtask

  task automatic test_small();
    logic [31:0] e;
    int busy_cnt, done_cnt;
    we8 = 1'b1; aw8 = 5'd3; sel8 = 3'd0; din8 = 32'hDEAD_BEEF;
    step();
    sel8 = 3'd1; din8 = 32'h1234_5678;
    step();
    we8 = 1'b0; ar8 = 5'd3;
    #1;
    checks++; if (dout8 !== 32'h1234_BEEF) begin errors++; $display("FAIL small_upper got %h exp 1234beef", dout8); end
    for (int a = 8; a < 32; a++) begin
      we8 = 1'b1; aw8 = 5'(a); sel8 = 3'd0; din8 = $urandom | 32'h1; ar8 = 5'(a);
      #1;
      checks++; if (dout8 !== 32'h0) begin errors++; $display("FAIL small_oob addr %0d got %h exp 0", a, dout8); end
      step();
    end
    we8 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      we8  = 1'($urandom_range(0, 1));
      aw8  = 5'($urandom_range(0, 12));
      sel8 = 3'($urandom_range(0, 7));
      din8 = $urandom;
      ar8  = ($urandom_range(0, 1) == 1) ? aw8 : 5'($urandom_range(0, 12));
      #1;
      e = exp_read8(int'(ar8));
      checks++; if (dout8 !== e) begin errors++; $display("FAIL small_rand i %0d addr %0d got %h exp %h", i, ar8, dout8, e); end
      step();
    end
    we8 = 1'b0;
    clr_req8 = 1'b1;
    step();
    clr_req8 = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (done8 === 1'b1) done_cnt++;
      step();
    end
    for (int i = 0; i < DEPTH8; i++) m_mem8[i] = 64'h0;
    checks++; if (busy_cnt != DEPTH8 - 1) begin errors++; $display("FAIL small_busy_len got %0d exp %0d", busy_cnt, DEPTH8 - 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL small_done_cnt got %0d exp 1", done_cnt); end
    for (int a = 1; a < DEPTH8; a++) begin
      ar8 = 5'(a);
      #1;
      checks++; if (dout8 !== 32'h0) begin errors++; $display("FAIL small_clr addr %0d got %h exp 0", a, dout8); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_forward();
    test_random();
    test_clear();
    test_clear_retrigger();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'h0;
    test_random();
    test_reset_mid_clear();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
